// File: rtl/camera_pkg.sv
// ---------------------------------------------------------------------------
// camera_pkg
// Shared definitions for the DVP camera transmitter:
//   state_t     - frame FSM states (IDLE, VSYNC, VBP, ACTIVE, VFP)
//   pixel_t     - one RGB565 pixel
//   BAR_*       - the eight colour-bar values of the internal test pattern
//   barColour() - maps a bar index (0..7) to its RGB565 colour
//   maxOf()     - elaboration-time helper for sizing counters
// ---------------------------------------------------------------------------
package camera_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } state_t;

    typedef logic [15:0] pixel_t;

    localparam pixel_t BAR_WHITE   = 16'hFFFF;
    localparam pixel_t BAR_YELLOW  = 16'hFFE0;
    localparam pixel_t BAR_CYAN    = 16'h07FF;
    localparam pixel_t BAR_GREEN   = 16'h07E0;
    localparam pixel_t BAR_MAGENTA = 16'hF81F;
    localparam pixel_t BAR_RED     = 16'hF800;
    localparam pixel_t BAR_BLUE    = 16'h001F;
    localparam pixel_t BAR_BLACK   = 16'h0000;

    // Bars run left to right from white to black, standard SMPTE-like order.
    function automatic pixel_t barColour(input logic [2:0] idx);
        case (idx)
            3'd0:    barColour = BAR_WHITE;
            3'd1:    barColour = BAR_YELLOW;
            3'd2:    barColour = BAR_CYAN;
            3'd3:    barColour = BAR_GREEN;
            3'd4:    barColour = BAR_MAGENTA;
            3'd5:    barColour = BAR_RED;
            3'd6:    barColour = BAR_BLUE;
            default: barColour = BAR_BLACK;
        endcase
    endfunction

    function automatic int maxOf(input int a, input int b);
        maxOf = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dvp_timing_counter.sv
// ---------------------------------------------------------------------------
// dvp_timing_counter
// Byte-slot and line counter for the DVP transmitter. The slot counter runs
// 0..SLOTS-1 and wraps at the end of every line; the line counter counts lines
// within the current FSM phase and wraps to 0 when the FSM says the current
// line is the last one of that phase.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   i_clear       - hold both counters at 0 (FSM idle)
//   i_advance     - step to the next slot (one pulse per pclk period)
//   i_lastLine    - current line is the final line of the current phase
//   o_slotNext    - slot index that the next advance will load
//   o_line        - current line index within the phase
//   o_lastSlot    - current slot is the last slot of the line
// ---------------------------------------------------------------------------
module dvp_timing_counter #(
    parameter int SLOTS  = 1424,
    parameter int SLOT_W = 11,
    parameter int LINE_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_advance,
    input  logic              i_lastLine,
    output logic [SLOT_W-1:0] o_slotNext,
    output logic [LINE_W-1:0] o_line,
    output logic              o_lastSlot
);

    logic [SLOT_W-1:0] r_slot;
    logic [LINE_W-1:0] r_line;
    logic [LINE_W-1:0] w_lineNext;

    // The next-slot values are exposed so the FSM can register the bus
    // contents for the upcoming slot on the same edge that advances us.
    always_comb begin
        o_lastSlot = (r_slot == SLOT_W'(SLOTS - 1));
        o_slotNext = o_lastSlot ? '0 : r_slot + 1'b1;
        w_lineNext = r_line;
        if (o_lastSlot) begin
            w_lineNext = i_lastLine ? '0 : r_line + 1'b1;
        end
    end

    assign o_line = r_line;

    // Counters only move once per pclk period; idle holds them cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot <= '0;
            r_line <= '0;
        end else if (i_clear) begin
            r_slot <= '0;
            r_line <= '0;
        end else if (i_advance) begin
            r_slot <= o_slotNext;
            r_line <= w_lineNext;
        end
    end

endmodule

// File: rtl/camera_dvp_tx.sv
// ---------------------------------------------------------------------------
// camera_dvp_tx
// Generates a DVP (parallel camera) byte stream: pclk_out = clk/2, with
// cam_data/cam_href/cam_vsync updated only on the clk edge that takes pclk_out
// low, so a receiver sampling on pclk rising edges always sees settled data.
// Pixels come from an RGB565 ready/valid stream or from internal colour bars.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   enable                  - start frames and keep streaming
//   test_pattern            - 1 = colour bars, 0 = pixel stream (per frame)
//   pix_data/valid/ready    - RGB565 input stream handshake
//   pclk_out                - DVP pixel clock, low while idle
//   cam_data/href/vsync     - DVP bus
//   frame_done, underrun    - single-clk status pulses
// ---------------------------------------------------------------------------
module camera_dvp_tx
    import camera_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        test_pattern,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        pclk_out,
    output logic [7:0]  cam_data,
    output logic        cam_href,
    output logic        cam_vsync,
    output logic        frame_done,
    output logic        underrun
);

    localparam int SLOTS      = 2 * H_ACTIVE + H_BLANK;
    localparam int HREF_SLOTS = 2 * H_ACTIVE;
    localparam int SLOT_W     = $clog2(SLOTS);
    localparam int LINE_MAX   = maxOf(maxOf(V_ACTIVE, VSYNC_LINES), maxOf(VBP_LINES, VFP_LINES));
    localparam int LINE_W     = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

    state_t            r_state;
    logic              r_pclk;
    logic              r_ready;
    logic [7:0]        r_data;
    logic              r_href;
    logic              r_vsync;
    logic              r_frameDone;
    logic              r_underrun;
    logic              r_testMode;
    pixel_t            r_pix;

    logic [SLOT_W-1:0] w_slotNext;
    logic [LINE_W-1:0] w_line;
    logic              w_lastSlot;
    logic              w_lastLine;
    logic              w_frameEnd;
    state_t            w_nextState;
    logic              w_nextHref;
    logic              w_nextEven;
    logic [2:0]        w_barIdx;
    pixel_t            w_pixel;
    int                w_stateLines;

    dvp_timing_counter #(
        .SLOTS  (SLOTS),
        .SLOT_W (SLOT_W),
        .LINE_W (LINE_W)
    ) u_timing (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (r_state == ST_IDLE),
        .i_advance  (r_pclk),
        .i_lastLine (w_lastLine),
        .o_slotNext (w_slotNext),
        .o_line     (w_line),
        .o_lastSlot (w_lastSlot)
    );

    // Work out what the next slot will be (state, href, pixel) so the bus
    // can be registered directly on the pclk falling edge.
    always_comb begin
        w_stateLines = VSYNC_LINES;
        case (r_state)
            ST_VBP:    w_stateLines = VBP_LINES;
            ST_ACTIVE: w_stateLines = V_ACTIVE;
            ST_VFP:    w_stateLines = VFP_LINES;
            default:   w_stateLines = VSYNC_LINES;
        endcase
        w_lastLine  = (w_line == LINE_W'(w_stateLines - 1));
        w_frameEnd  = (r_state == ST_VFP) && w_lastSlot && w_lastLine;
        w_nextState = r_state;
        if (w_lastSlot && w_lastLine) begin
            case (r_state)
                ST_VSYNC:  w_nextState = ST_VBP;
                ST_VBP:    w_nextState = ST_ACTIVE;
                ST_ACTIVE: w_nextState = ST_VFP;
                ST_VFP:    w_nextState = enable ? ST_VSYNC : ST_IDLE;
                default:   w_nextState = ST_IDLE;
            endcase
        end
        w_nextHref = (w_nextState == ST_ACTIVE) && (w_slotNext < SLOT_W'(HREF_SLOTS));
        w_nextEven = w_nextHref && !w_slotNext[0];
        w_barIdx   = 3'((32'(w_slotNext >> 1) * 32'd8) / 32'(H_ACTIVE));
        if (r_testMode) begin
            w_pixel = barColour(w_barIdx);
        end else if (pix_valid) begin
            w_pixel = pix_data;
        end else begin
            w_pixel = '0;
        end
    end

    // Frame FSM. In idle pclk is parked low; otherwise every clk toggles pclk.
    // The low->high half only raises pix_ready ahead of an even href slot;
    // the high->low half advances the slot and loads the new bus value, so the
    // bus never moves while pclk rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pclk      <= 1'b0;
            r_ready     <= 1'b0;
            r_data      <= 8'h00;
            r_href      <= 1'b0;
            r_vsync     <= 1'b0;
            r_frameDone <= 1'b0;
            r_underrun  <= 1'b0;
            r_testMode  <= 1'b0;
            r_pix       <= '0;
        end else begin
            r_frameDone <= 1'b0;
            r_underrun  <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_pclk  <= 1'b0;
                r_ready <= 1'b0;
                r_href  <= 1'b0;
                r_data  <= 8'h00;
                if (enable) begin
                    r_state    <= ST_VSYNC;
                    r_vsync    <= 1'b1;
                    r_testMode <= test_pattern;
                end
            end else if (!r_pclk) begin
                r_pclk  <= 1'b1;
                r_ready <= w_nextEven && !r_testMode;
            end else begin
                r_pclk  <= 1'b0;
                r_ready <= 1'b0;
                r_state <= w_nextState;
                r_vsync <= (w_nextState == ST_VSYNC);
                r_href  <= w_nextHref;
                if (w_frameEnd) begin
                    r_frameDone <= 1'b1;
                end
                if (r_state == ST_VFP && w_nextState == ST_VSYNC) begin
                    r_testMode <= test_pattern;
                end
                if (w_nextEven) begin
                    r_pix  <= w_pixel;
                    r_data <= w_pixel[15:8];
                    if (!r_testMode && !pix_valid) begin
                        r_underrun <= 1'b1;
                    end
                end else if (w_nextHref) begin
                    r_data <= r_pix[7:0];
                end else begin
                    r_data <= 8'h00;
                end
            end
        end
    end

    assign pix_ready  = r_ready;
    assign pclk_out   = r_pclk;
    assign cam_data   = r_data;
    assign cam_href   = r_href;
    assign cam_vsync  = r_vsync;
    assign frame_done = r_frameDone;
    assign underrun   = r_underrun;

endmodule
